block_unloader: RTL and testbench

//  Read-back end of the control memory. CTRL_MEMORY stores one tile block per address
//  (BLOCK_WIDTH^2 words). Given a base address and a block count, this block reads

---
 rtl/block_unloader.sv | 125 ++++++++++++
 tb/tb_block_unloader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_unloader.sv
// Drains tile blocks from the control memory: reads one block per address and
// serialises it word by word, LSB word first, onto a valid/ready stream.
module block_unloader #(
  parameter int BLOCK_BITS = 3,
  parameter int ADDR_BITS  = 6,
  parameter int WORD_BITS  = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [ADDR_BITS-1:0]                          base_addr,
  input  logic [ADDR_BITS:0]                            count,
  output logic                                          rd_en,
  output logic [ADDR_BITS-1:0]                          rd_addr,
  input  logic [WORD_BITS*(2**(2*BLOCK_BITS))-1:0]      rd_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [WORD_BITS-1:0]                          out_data,
  output logic                                          out_last,
  output logic                                          busy,
  output logic                                          done,
  output logic [2:0]                                    fsm_state
);

  localparam int NW    = 2**(2*BLOCK_BITS);
  localparam int BW    = WORD_BITS*NW;
  localparam int IDX_W = 2*BLOCK_BITS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state, state_nx;
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS:0]   remaining;
  logic [IDX_W-1:0]     idx;
  logic [BW-1:0]        shreg;
  logic                 hs;
  logic                 last_word;
  logic                 last_block;

  // Stream handshake: a word transfers on any cycle where out_valid and out_ready
  // are both high. out_valid/out_data hold steady until that happens; out_ready
  // has no effect while out_valid is low.
  assign hs         = (state == S_SHIFT) && out_ready;
  assign last_word  = (idx == IDX_W'(NW-1));
  assign last_block = (remaining == (ADDR_BITS+1)'(1));
  assign fsm_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      idx       <= '0;
      shreg     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= count;
          end
        end
        S_WAIT: begin
          shreg <= rd_data;
          idx   <= '0;
        end
        S_SHIFT: begin
          if (hs) begin
            shreg <= shreg >> WORD_BITS;
            idx   <= idx + IDX_W'(1);
            // Address wraps naturally at the top of the memory.
            if (last_word) begin
              remaining <= remaining - (ADDR_BITS+1)'(1);
              addr      <= addr + ADDR_BITS'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    rd_en     = 1'b0;
    rd_addr   = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = (count == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        rd_en    = 1'b1;
        rd_addr  = addr;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        out_valid = 1'b1;
        out_data  = shreg[WORD_BITS-1:0];
        out_last  = last_word && last_block;
        if (hs && last_word) state_nx = last_block ? S_DONE : S_READ;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_block_unloader.sv
// Directed bench for block_unloader: memory model, scoreboard of expected
// words/addresses, and a negedge monitor that pops and compares on every transfer.
module tb_block_unloader;
  localparam int BLOCK_BITS = 3;
  localparam int ADDR_BITS  = 6;
  localparam int WORD_BITS  = 16;
  localparam int NW         = 64;
  localparam int BW         = WORD_BITS*NW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [ADDR_BITS-1:0] base_addr = '0;
  logic [ADDR_BITS:0]   count = '0;
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [BW-1:0]        rd_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [WORD_BITS-1:0] out_data;
  logic                 out_last;
  logic                 busy;
  logic                 done;
  logic [2:0]           fsm_state;

  block_unloader #(.BLOCK_BITS(BLOCK_BITS), .ADDR_BITS(ADDR_BITS), .WORD_BITS(WORD_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q = 1'b1;
  int   ready_mode = 0;
  int   rpat = 0;

  function automatic logic [WORD_BITS-1:0] word_of(input logic [ADDR_BITS-1:0] a, input int i);
    if (a == 6'd5) return WORD_BITS'(i + 100);
    return {a, 10'(i)};
  endfunction

  function automatic logic [BW-1:0] blk(input logic [ADDR_BITS-1:0] a);
    logic [BW-1:0] b;
    for (int i = 0; i < NW; i++) b[WORD_BITS*i +: WORD_BITS] = word_of(a, i);
    return b;
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_q   <= rst;
    rd_data <= rd_en ? blk(rd_addr) : {NW{16'hDEAD}};
  end

  always @(posedge clk) begin
    #1;
    out_ready = (ready_mode == 0) ? 1'b1 : (rpat % 3 == 0);
    rpat++;
  end

  // ---------------- scoreboard state ----------------
  logic [WORD_BITS:0]   exp_q[$];
  logic [ADDR_BITS-1:0] addr_q[$];
  int checks = 0;
  int errors = 0;
  int hs_cnt, last_cnt, rd_cnt, done_cnt, busy_cnt;
  int first_rd, first_vld, done_cyc;
  int gap_len;
  bit seen_valid;
  bit prev_valid, prev_hs;
  logic [WORD_BITS-1:0] prev_data;

  task automatic monitor_step();
    logic [WORD_BITS:0]   e;
    logic [ADDR_BITS-1:0] ea;
    if (rst_q) begin
      prev_valid = 1'b0;
      seen_valid = 1'b0;
      return;
    end
    if (rd_en) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      checks++;
      if (addr_q.size() == 0) begin
        errors++; $display("FAIL rd_addr unexpected read got=%0d", rd_addr);
      end else begin
        ea = addr_q.pop_front();
        if (rd_addr !== ea) begin
          errors++; $display("FAIL rd_addr got=%0d exp=%0d", rd_addr, ea);
        end
      end
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    if (prev_valid && !prev_hs) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== prev_data) begin
        errors++; $display("FAIL stall_hold got valid=%b data=%h exp valid=1 data=%h", out_valid, out_data, prev_data);
      end
    end
    if (out_valid) begin
      if (first_vld < 0) first_vld = cyc;
      if (gap_len > 0) begin
        checks++;
        if (gap_len != 2) begin errors++; $display("FAIL block_gap got=%0d exp=2", gap_len); end
      end
      gap_len = 0;
      seen_valid = 1'b1;
    end else if (seen_valid && busy) begin
      gap_len++;
    end
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (out_last) last_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL stream unexpected word got=%h", out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          errors++; $display("FAIL stream got last=%b data=%h exp last=%b data=%h", out_last, out_data, e[WORD_BITS], e[WORD_BITS-1:0]);
        end
      end
    end
    prev_valid = out_valid;
    prev_hs    = out_valid && out_ready;
    prev_data  = out_data;
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++; $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic clear_stats();
    hs_cnt = 0; last_cnt = 0; rd_cnt = 0; done_cnt = 0; busy_cnt = 0;
    first_rd = -1; first_vld = -1; done_cyc = -1; gap_len = 0; seen_valid = 1'b0;
  endtask

  task automatic push_expected(input logic [ADDR_BITS-1:0] base, input int cnt);
    logic [ADDR_BITS-1:0] a;
    for (int b = 0; b < cnt; b++) begin
      a = base + ADDR_BITS'(b);
      addr_q.push_back(a);
      for (int i = 0; i < NW; i++)
        exp_q.push_back({(b == cnt-1) && (i == NW-1), word_of(a, i)});
    end
  endtask

  // ---------------- driver ----------------
  // exp_done: expected done offset from the start cycle (-1 = not checked);
  // also the expected number of busy cycles.
  task automatic do_run(input string name, input logic [ADDR_BITS-1:0] base, input int cnt,
                        input int rmode, input bit poke, input bit hold_start, input int exp_done);
    int t0;
    int n;
    push_expected(base, cnt);
    clear_stats();
    ready_mode = rmode;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; count = 7'(cnt); t0 = cyc;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    n = 0;
    while (done_cyc < 0 && n < 10000) begin
      @(posedge clk); #1;
      n++;
      start = poke && (cyc == t0 + 10);
      if (start) begin base_addr = 6'd9; count = 7'd1; end
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int({name, " timeout"}, (done_cyc >= 0) ? 1 : 0, 1);
    check_int({name, " done_pulses"}, done_cnt, 1);
    check_int({name, " handshakes"}, hs_cnt, cnt*NW);
    check_int({name, " last_count"}, last_cnt, (cnt != 0) ? 1 : 0);
    check_int({name, " reads"}, rd_cnt, cnt);
    check_int({name, " words_left"}, exp_q.size(), 0);
    check_int({name, " addrs_left"}, addr_q.size(), 0);
    check_int({name, " idle_after"}, int'(busy), 0);
    if (exp_done >= 0) begin
      check_int({name, " done_latency"}, done_cyc - t0, exp_done);
      check_int({name, " busy_cycles"}, busy_cnt, exp_done);
      if (cnt > 0) begin
        check_int({name, " rd_latency"}, first_rd - t0, 1);
        check_int({name, " valid_latency"}, first_vld - t0, 3);
      end else begin
        check_int({name, " no_valid"}, first_vld, -1);
      end
    end
    exp_q.delete();
    addr_q.delete();
  endtask

  // ---------------- main sequence + monitor ----------------
  initial begin
    clear_stats();
    prev_valid = 1'b0; prev_hs = 1'b0; prev_data = '0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset_outputs", int'({rd_en, rd_addr, out_valid, out_data, out_last, busy, done}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 1: reset in the middle of SHIFT
    push_expected(6'd20, 2);
    clear_stats();
    ready_mode = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd20; count = 7'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_int("t1 in_shift", int'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_int("t1 reset_outputs", int'({out_valid, rd_en, busy, done}), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check_int("t1 no_done", done_cnt, 0);
    check_int("t1 idle", int'(busy), 0);

    // Test 2: single block, free-flowing sink
    do_run("t2", 6'd5, 1, 0, 1'b0, 1'b0, 67);
    // Test 3: single block with backpressure
    do_run("t3", 6'd5, 1, 1, 1'b0, 1'b0, -1);
    // Test 4: three blocks wrapping past the top address
    do_run("t4", 6'd62, 3, 0, 1'b0, 1'b0, -1);
    // Test 5: zero blocks; start also held into the DONE cycle
    do_run("t5", 6'd7, 0, 0, 1'b0, 1'b1, 1);
    // Test 6: start with base 9 re-asserted mid-stream
    do_run("t6", 6'd20, 2, 0, 1'b1, 1'b0, -1);
    // Full memory sweep
    do_run("t7", 6'd10, 64, 0, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
